// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall back-pressure and synchronous flush.
// Define PIPE_STAGE_REG_SKID_EN for a 2-entry skid stage with a registered in_ready.
module pipe_stage_reg #(
   parameter int DATA_W = 69,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
);

   logic [DATA_W-1:0] data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   assign out_data = data_q;
   assign out_ctrl = ctrl_q;

`ifdef PIPE_STAGE_REG_SKID_EN

   // Bit 0 is the main-entry valid, bit 1 the skid-entry valid.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } occ_e;

   occ_e              state_q, state_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic              in_fire, out_fire;

   assign out_valid = state_q[0];
   assign in_ready  = ~state_q[1];
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      // NOTE: every next-state signal gets a hold default first, so no path infers a latch.
      state_d     = state_q;
      data_d      = data_q;
      ctrl_d      = ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) begin
         state_d     = ST_EMPTY;
         ctrl_d      = '0;
         skid_ctrl_d = '0;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d = ST_ONE;
                  data_d  = in_data;
                  ctrl_d  = in_ctrl;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  data_d = in_data;
                  ctrl_d = in_ctrl;
               end else if (in_fire) begin
                  state_d     = ST_FULL;
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
                  ctrl_d  = '0;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  state_d     = ST_ONE;
                  data_d      = skid_data_q;
                  ctrl_d      = skid_ctrl_q;
                  skid_ctrl_d = '0;
               end
            end
            default: begin
               state_d     = ST_EMPTY;
               ctrl_d      = '0;
               skid_ctrl_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments; reset is synchronous, sampled only on the edge.
      if (rst) begin
         state_q     <= ST_EMPTY;
         data_q      <= '0;
         ctrl_q      <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         ctrl_q      <= ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
      end
   end

`else

   logic valid_q, valid_d;

   assign out_valid = valid_q;
   assign in_ready  = out_ready | ~valid_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      if (flush) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (in_ready) begin
         valid_d = in_valid;
         if (in_valid) begin
            data_d = in_data;
            ctrl_d = in_ctrl;
         end else begin
            ctrl_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
      end
   end

`endif

   // An empty slot must never carry live control, and a stalled beat must not move.
   a_ctrl_zero_when_idle : assert property (@(posedge clk) disable iff (rst)
      !out_valid |-> (out_ctrl == '0));

   a_hold_on_stall : assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based occupancy model plus directed literal checks.
// Build with PIPE_STAGE_REG_SKID_EN defined to exercise the skid configuration.
module tb_pipe_stage_reg;

   localparam int DATA_W = 69;
   localparam int CTRL_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic [CTRL_W-1:0] in_ctrl = '0;
   logic              flush = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;

   int n_vec = 0;
   int n_err = 0;

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: the stage is a FIFO of accepted beats, capacity 1 (plain) or 2 (skid).
   typedef struct {
      logic [DATA_W-1:0] d;
      logic [CTRL_W-1:0] c;
   } beat_t;

   beat_t             mq[$];
   logic [DATA_W-1:0] m_held = '0;
   bit                model_live = 0;

   function automatic bit m_ready();
`ifdef PIPE_STAGE_REG_SKID_EN
      return mq.size() < 2;
`else
      return (mq.size() == 0) || (out_ready == 1'b1);
`endif
   endfunction

   always @(posedge clk) begin
      bit ifire, ofire;
      beat_t b;
      ifire = (in_valid == 1'b1) && m_ready();
      ofire = (mq.size() > 0) && (out_ready == 1'b1);
      if (rst) begin
         mq.delete();
         m_held = '0;
      end else if (flush) begin
         if (mq.size() > 0) m_held = mq[0].d;
         mq.delete();
      end else begin
         if (ofire) begin
            m_held = mq[0].d;
            void'(mq.pop_front());
         end
         if (ifire) begin
            b.d = in_data;
            b.c = in_ctrl;
            mq.push_back(b);
         end
      end
      model_live = 1;
   end

   always @(negedge clk) begin
      if (model_live) begin
         check("cmp_valid", DATA_W'(out_valid), DATA_W'(mq.size() > 0));
         check("cmp_data",  out_data, (mq.size() > 0) ? mq[0].d : m_held);
         check("cmp_ctrl",  DATA_W'(out_ctrl), (mq.size() > 0) ? DATA_W'(mq[0].c) : '0);
         check("cmp_ready", DATA_W'(in_ready), DATA_W'(m_ready()));
      end
   end

   // Inputs change just after the rising edge; returns at the falling edge of the same cycle.
   task automatic drive(input logic v, input int d, input logic [CTRL_W-1:0] c,
                        input logic ordy, input logic fl, input logic r);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = DATA_W'(d);
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
      rst       = r;
      @(negedge clk);
   endtask

   task automatic expect_out(input string tag, input logic v, input int d,
                             input logic [CTRL_W-1:0] c, input logic rdy);
      check({tag, "_valid"}, DATA_W'(out_valid), DATA_W'(v));
      check({tag, "_data"},  out_data, DATA_W'(d));
      check({tag, "_ctrl"},  DATA_W'(out_ctrl), DATA_W'(c));
      check({tag, "_ready"}, DATA_W'(in_ready), DATA_W'(rdy));
   endtask

   initial begin
      // Reset for two cycles, then stream 1..8 at full rate.
      drive(0, 0, 4'h0, 1, 0, 1);
      drive(0, 0, 4'h0, 1, 0, 1);
      for (int k = 1; k <= 8; k++) begin
         drive(1, k, 4'(k), 1, 0, 0);
         if (k == 1) expect_out("reset", 0, 0, 4'h0, 1);
         else        expect_out("stream", 1, k - 1, 4'(k - 1), 1);
      end

      // Bubble with garbage control on the bus.
      drive(0, 77, 4'hF, 1, 0, 0);
      expect_out("last_beat", 1, 8, 4'h8, 1);
      drive(0, 0, 4'h0, 1, 0, 0);
      expect_out("bubble", 0, 8, 4'h0, 1);

`ifdef PIPE_STAGE_REG_SKID_EN
      // Stall while streaming 10,11,12: 11 lands in the skid entry.
      drive(1, 10, 4'hA, 1, 0, 0);
      drive(1, 11, 4'hB, 0, 0, 0);
      expect_out("skid_first", 1, 10, 4'hA, 1);
      drive(1, 12, 4'hC, 0, 0, 0);
      expect_out("skid_full", 1, 10, 4'hA, 0);
      drive(1, 12, 4'hC, 1, 0, 0);
      expect_out("skid_release", 1, 10, 4'hA, 0);
      drive(1, 12, 4'hC, 1, 0, 0);
      expect_out("skid_second", 1, 11, 4'hB, 1);
      drive(0, 0, 4'h0, 1, 0, 0);
      expect_out("skid_third", 1, 12, 4'hC, 1);
      drive(0, 0, 4'h0, 1, 0, 0);
      expect_out("skid_drained", 0, 12, 4'h0, 1);
`else
      // Three-cycle stall: in_ready follows out_ready in the same cycle.
      drive(1, 20, 4'h4, 1, 0, 0);
      drive(1, 21, 4'h5, 1, 0, 0);
      expect_out("pre_stall", 1, 20, 4'h4, 1);
      for (int s = 0; s < 3; s++) begin
         drive(1, 22, 4'h6, 0, 0, 0);
         expect_out("stall", 1, 21, 4'h5, 0);
      end
      drive(1, 22, 4'h6, 1, 0, 0);
      expect_out("stall_release", 1, 21, 4'h5, 1);
      drive(1, 23, 4'h7, 1, 0, 0);
      expect_out("post_stall", 1, 22, 4'h6, 1);
      drive(0, 0, 4'h0, 1, 0, 0);
      expect_out("post_stall2", 1, 23, 4'h7, 1);
      drive(0, 0, 4'h0, 1, 0, 0);
`endif

      // Flush while stalled (FULL in the skid build): 99 must be dropped.
      drive(1, 30, 4'h1, 1, 0, 0);
      drive(1, 31, 4'h2, 0, 0, 0);
      drive(1, 99, 4'h3, 0, 1, 0);
      drive(0, 0, 4'h0, 1, 0, 0);
      expect_out("flush", 0, 30, 4'h0, 1);
      drive(0, 0, 4'h0, 1, 0, 0);
      expect_out("flush_idle", 0, 30, 4'h0, 1);

      // Reset in the middle of a stall, then one beat 1 cycle later.
      drive(1, 40, 4'h8, 1, 0, 0);
      drive(1, 41, 4'h9, 0, 0, 0);
      drive(1, 42, 4'hA, 0, 0, 1);
      drive(1, 50, 4'hD, 1, 0, 0);
      expect_out("mid_rst", 0, 0, 4'h0, 1);
      drive(0, 0, 4'h0, 1, 0, 0);
      expect_out("after_rst", 1, 50, 4'hD, 1);

      // Mixed valid/ready pattern with one flush, checked by the model only.
      for (int i = 0; i < 24; i++)
         drive((i % 3) != 0, 100 + i, 4'(100 + i), (i % 4) != 1, i == 17, 0);

      for (int i = 0; i < 4; i++)
         drive(0, 0, 4'h0, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
